// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared constants, types and helpers for the vision pipeline
package vision_pkg;

   localparam int unsigned H_ACTIVE_DEF = 1280;
   localparam int unsigned V_ACTIVE_DEF = 720;

   localparam int X_W   = 11;
   localparam int Y_W   = 10;
   localparam int CNT_W = 20;

   // Cr = 128 + ((112*R - 94*G - 18*B) >>> 8)
   localparam int CR_COEF_R = 112;
   localparam int CR_COEF_G = 94;
   localparam int CR_COEF_B = 18;
   localparam int CR_OFFSET = 128;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      ACTIVE     = 1'b1
   } mask_state_t;

   // Side-band that travels alongside the colour data through the pipeline
   typedef struct packed {
      logic           valid;
      logic           sof;
      logic           last;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } px_side_t;

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic logic [7:0] expand6(input logic [5:0] c);
      return {c, c[5:4]};
   endfunction

endpackage

// File: rtl/rgb565_to_cr.sv
// rtl/rgb565_to_cr.sv - RGB565 to Cr conversion, pipeline stages S1 to S3
module rgb565_to_cr
   import vision_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   input  logic [15:0]    pixel_in,
   input  logic [X_W-1:0] hcount_in,
   input  logic [Y_W-1:0] vcount_in,
   input  logic           data_valid_in,
   output px_side_t       side_out,
   output logic [7:0]     cr_out
);

   px_side_t           in_side;
   px_side_t           s1_side;
   px_side_t           s2_side;
   logic [7:0]         s1_r8, s1_g8, s1_b8;
   logic [15:0]        s2_pr, s2_pg, s2_pb;
   logic signed [16:0] s3_sum;
   logic signed [9:0]  s3_cr_wide;
   logic [7:0]         s3_cr_clamped;

   // Eligibility: blanking samples never enter the pipeline as valid pixels
   always_comb begin
      in_side       = '0;
      in_side.valid = data_valid_in
                      && (hcount_in < X_W'(H_ACTIVE))
                      && (vcount_in < Y_W'(V_ACTIVE));
      in_side.sof   = in_side.valid && (hcount_in == '0) && (vcount_in == '0);
      in_side.last  = in_side.valid
                      && (hcount_in == X_W'(H_ACTIVE - 1))
                      && (vcount_in == Y_W'(V_ACTIVE - 1));
      in_side.x     = hcount_in;
      in_side.y     = vcount_in;
   end

   // S1: capture pixel and expand each channel to 8 bits
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_side <= '0;
         s1_r8   <= '0;
         s1_g8   <= '0;
         s1_b8   <= '0;
      end else begin
         s1_side <= in_side;
         s1_r8   <= expand5(pixel_in[15:11]);
         s1_g8   <= expand6(pixel_in[10:5]);
         s1_b8   <= expand5(pixel_in[4:0]);
      end
   end

   // S2: the three coefficient products, all non-negative magnitudes
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s2_side <= '0;
         s2_pr   <= '0;
         s2_pg   <= '0;
         s2_pb   <= '0;
      end else begin
         s2_side <= s1_side;
         s2_pr   <= 16'(s1_r8) * 16'(CR_COEF_R);
         s2_pg   <= 16'(s1_g8) * 16'(CR_COEF_G);
         s2_pb   <= 16'(s1_b8) * 16'(CR_COEF_B);
      end
   end

   // Signed sum, floor shift, offset and defensive clamp to 0..255
   always_comb begin
      s3_sum     = $signed({1'b0, s2_pr}) - $signed({1'b0, s2_pg}) - $signed({1'b0, s2_pb});
      s3_cr_wide = 10'(s3_sum >>> 8) + 10'(CR_OFFSET);
      if (s3_cr_wide < 10'sd0) begin
         s3_cr_clamped = 8'd0;
      end else if (s3_cr_wide > 10'sd255) begin
         s3_cr_clamped = 8'd255;
      end else begin
         s3_cr_clamped = s3_cr_wide[7:0];
      end
   end

   // S3: register the Cr value with its side-band
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         side_out <= '0;
         cr_out   <= '0;
      end else begin
         side_out <= s2_side;
         cr_out   <= s3_cr_clamped;
      end
   end

endmodule

// File: rtl/color_mask.sv
// rtl/color_mask.sv - Cr window mask with frame tracking and masked-pixel count
module color_mask
   import vision_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [15:0]      pixel_in,
   input  logic [X_W-1:0]   hcount_in,
   input  logic [Y_W-1:0]   vcount_in,
   input  logic             data_valid_in,
   input  logic [7:0]       lower_in,
   input  logic [7:0]       upper_in,
   output logic [X_W-1:0]   x_out,
   output logic [Y_W-1:0]   y_out,
   output logic             valid_out,
   output logic             tabulate_out,
   output logic [CNT_W-1:0] pixel_count_out
);

   px_side_t         s3_side;
   logic [7:0]       s3_cr;
   mask_state_t      state, state_nxt;
   logic [7:0]       pend_lo, pend_hi;
   logic [7:0]       lat_lo, lat_hi;
   logic [7:0]       eff_lo, eff_hi;
   logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
   logic             last_q;
   logic             start_in;
   logic             frame_go;
   logic             emit;
   logic             frame_end;

   rgb565_to_cr #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_cr (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .pixel_in      (pixel_in),
      .hcount_in     (hcount_in),
      .vcount_in     (vcount_in),
      .data_valid_in (data_valid_in),
      .side_out      (s3_side),
      .cr_out        (s3_cr)
   );

   assign start_in = data_valid_in && (hcount_in == '0) && (vcount_in == '0);

   // Bounds are sampled when (0,0) is accepted but only take over from the
   // running bounds when that pixel reaches the compare stage, so pixels of
   // the previous frame still in flight keep their own window
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend_lo <= '0;
         pend_hi <= '0;
      end else if (start_in) begin
         pend_lo <= lower_in;
         pend_hi <= upper_in;
      end
   end

   // FSM state register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= WAIT_FRAME;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: the first frame start seen at the compare stage arms the block
   always_comb begin
      state_nxt = state;
      if (s3_side.valid && s3_side.sof) begin
         state_nxt = ACTIVE;
      end
   end

   // FSM outputs: window compare, emission, frame end and counter update
   always_comb begin
      frame_go  = s3_side.valid && ((state == ACTIVE) || s3_side.sof);
      eff_lo    = s3_side.sof ? pend_lo : lat_lo;
      eff_hi    = s3_side.sof ? pend_hi : lat_hi;
      emit      = frame_go && (s3_cr >= eff_lo) && (s3_cr <= eff_hi);
      frame_end = frame_go && s3_side.last;
      cnt_base  = (last_q || (s3_side.valid && s3_side.sof)) ? '0 : cnt;
      cnt_nxt   = (emit && (cnt_base != {CNT_W{1'b1}})) ? cnt_base + 1'b1 : cnt_base;
   end

   // S4 registers, running bounds, count and the trailing tabulate pulse
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         lat_lo          <= '0;
         lat_hi          <= '0;
         x_out           <= '0;
         y_out           <= '0;
         valid_out       <= 1'b0;
         tabulate_out    <= 1'b0;
         pixel_count_out <= '0;
         cnt             <= '0;
         last_q          <= 1'b0;
      end else begin
         if (s3_side.valid && s3_side.sof) begin
            lat_lo <= pend_lo;
            lat_hi <= pend_hi;
         end
         valid_out <= emit;
         if (emit) begin
            x_out <= s3_side.x;
            y_out <= s3_side.y;
         end
         last_q       <= frame_end;
         tabulate_out <= last_q;
         if (last_q) begin
            pixel_count_out <= cnt;
         end
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_color_mask.sv
// tb/tb_color_mask.sv - self-checking bench for color_mask on a reduced frame size
module tb_color_mask;

   localparam int H = 16;
   localparam int V = 8;
   localparam logic [15:0] WHITE = 16'hFFFF;
   localparam logic [15:0] RED   = 16'hF800;
   localparam logic [15:0] GREEN = 16'h07E0;

   typedef struct { int due; int x; int y; } px_exp_t;
   typedef struct { int due; int cnt; } tab_exp_t;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [15:0] pixel_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        data_valid_in;
   logic [7:0]  lower_in;
   logic [7:0]  upper_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        valid_out;
   logic        tabulate_out;
   logic [19:0] pixel_count_out;

   px_exp_t  px_q[$];
   tab_exp_t tab_q[$];
   px_exp_t  pe;
   tab_exp_t te;
   int cyc = 0;
   int checks = 0;
   int passes = 0;
   int m_lo, m_hi, m_cnt;
   bit m_active = 1'b0;

   color_mask #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .pixel_in        (pixel_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .data_valid_in   (data_valid_in),
      .lower_in        (lower_in),
      .upper_in        (upper_in),
      .x_out           (x_out),
      .y_out           (y_out),
      .valid_out       (valid_out),
      .tabulate_out    (tabulate_out),
      .pixel_count_out (pixel_count_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int cr_of(input logic [15:0] p);
      int r8, g8, b8, s, c;
      r8 = int'({p[15:11], p[15:13]});
      g8 = int'({p[10:5], p[10:9]});
      b8 = int'({p[4:0], p[4:2]});
      s  = 112 * r8 - 94 * g8 - 18 * b8;
      c  = 128 + (s >>> 8);
      if (c < 0) c = 0;
      if (c > 255) c = 255;
      return c;
   endfunction

   // Drive one sample and record what the block must produce for it
   task automatic drive(input logic dv, input int h, input int v, input logic [15:0] pix);
      @(negedge clk_in);
      data_valid_in = dv;
      hcount_in     = 11'(h);
      vcount_in     = 10'(v);
      pixel_in      = pix;
      if (dv && h == 0 && v == 0) begin
         m_lo = int'(lower_in);
         m_hi = int'(upper_in);
         m_active = 1'b1;
         m_cnt = 0;
      end
      if (dv && m_active && h < H && v < V) begin
         if (cr_of(pix) >= m_lo && cr_of(pix) <= m_hi) begin
            px_q.push_back('{due: cyc + 4, x: h, y: v});
            m_cnt++;
         end
         if (h == H - 1 && v == V - 1) begin
            tab_q.push_back('{due: cyc + 5, cnt: m_cnt});
            m_cnt = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 16'h0000);
   endtask

   task automatic frame(input logic [15:0] base, input int sx, input int sy, input logic [15:0] spix,
                        input int chg_row, input logic [7:0] nlo, input logic [7:0] nhi, input int stop_row);
      for (int v = 0; v < V; v++) begin
         if (v == stop_row) return;
         if (v == chg_row) begin
            lower_in = nlo;
            upper_in = nhi;
         end
         for (int h = 0; h < H + 2; h++) drive(1'b1, h, v, (h == sx && v == sy) ? spix : base);
      end
      for (int h = 0; h < 3; h++) drive(1'b1, h, V, base);
      idle(3);
   endtask

   task automatic reset_now();
      @(posedge clk_in);
      #2;
      rst_n_in = 1'b0;
      px_q.delete();
      tab_q.delete();
      m_active = 1'b0;
      m_cnt = 0;
      #1;
      check("reset_drops_valid", int'(valid_out), 0);
   endtask

   task automatic release_reset();
      @(posedge clk_in);
      #2;
      rst_n_in = 1'b1;
   endtask

   // Scoreboard side: every output event must match the head of its queue
   always @(negedge clk_in) begin
      if (rst_n_in === 1'b1) begin
         if (valid_out) begin
            check("valid_expected", int'(px_q.size() != 0), 1);
            if (px_q.size() != 0) begin
               pe = px_q.pop_front();
               check("x_out", int'(x_out), pe.x);
               check("y_out", int'(y_out), pe.y);
               check("valid_latency", cyc, pe.due);
            end
         end
         if (tabulate_out) begin
            check("tab_expected", int'(tab_q.size() != 0), 1);
            check("tab_no_valid", int'(valid_out), 0);
            if (tab_q.size() != 0) begin
               te = tab_q.pop_front();
               check("pixel_count", int'(pixel_count_out), te.cnt);
               check("tab_latency", cyc, te.due);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in = 1'b0;
      data_valid_in = 1'b0;
      pixel_in = '0;
      hcount_in = '0;
      vcount_in = '0;
      lower_in = '0;
      upper_in = '0;
      idle(3);
      check("rst_valid", int'(valid_out), 0);
      check("rst_tab", int'(tabulate_out), 0);
      check("rst_x", int'(x_out), 0);
      check("rst_y", int'(y_out), 0);
      check("rst_count", int'(pixel_count_out), 0);
      release_reset();

      // single red pixel in a white frame
      lower_in = 8'd200;
      upper_in = 8'd255;
      frame(WHITE, 10, 5, RED, -1, 8'd0, 8'd0, -1);
      idle(8);
      check("t1_count", int'(pixel_count_out), 1);
      check("t1_hold_x", int'(x_out), 10);
      check("t1_hold_y", int'(y_out), 5);

      // full green frame in window
      lower_in = 8'd30;
      upper_in = 8'd40;
      frame(GREEN, -1, -1, GREEN, -1, 8'd0, 8'd0, -1);
      idle(8);
      check("t2_count", int'(pixel_count_out), H * V);

      // inverted window masks nothing but still tabulates
      lower_in = 8'd200;
      upper_in = 8'd100;
      frame(RED, -1, -1, RED, -1, 8'd0, 8'd0, -1);
      idle(8);
      check("t3_count", int'(pixel_count_out), 0);

      // reset mid-frame, release at the centre, wait for the next frame
      lower_in = 8'd200;
      upper_in = 8'd255;
      frame(RED, -1, -1, RED, -1, 8'd0, 8'd0, 3);
      reset_now();
      idle(3);
      release_reset();
      for (int v = V / 2; v < V; v++)
         for (int h = (v == V / 2) ? H / 2 : 0; h < H + 2; h++) drive(1'b1, h, v, RED);
      idle(8);
      check("t4_no_tab_count", int'(pixel_count_out), 0);
      frame(RED, -1, -1, RED, -1, 8'd0, 8'd0, -1);
      idle(8);
      check("t4_count", int'(pixel_count_out), H * V);

      // bounds change mid-frame applies to the next frame only
      lower_in = 8'd200;
      upper_in = 8'd255;
      frame(RED, -1, -1, RED, V / 2, 8'd0, 8'd50, -1);
      frame(RED, -1, -1, RED, -1, 8'd0, 8'd0, -1);
      idle(8);
      check("t5_count", int'(pixel_count_out), 0);

      // early restart: no tabulate, next frame reports only itself
      lower_in = 8'd200;
      upper_in = 8'd255;
      frame(RED, 3, 2, WHITE, -1, 8'd0, 8'd0, 5);
      frame(RED, 3, 2, WHITE, -1, 8'd0, 8'd0, -1);
      idle(10);
      check("t6_count", int'(pixel_count_out), H * V - 1);

      check("px_queue_empty", px_q.size(), 0);
      check("tab_queue_empty", tab_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
